// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - streaming multi-word frame parity checker with result buffer and error counter
module parity_frame_checker #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk_pad,
    input  logic              rst_n_pad,
    input  logic              odd_mode_pad,
    input  logic              in_valid_pad,
    output logic              in_ready_pad,
    input  logic [DATA_W-1:0] in_data_pad,
    input  logic              in_last_pad,
    input  logic              in_par_pad,
    output logic              out_valid_pad,
    input  logic              out_ready_pad,
    output logic              out_par_pad,
    output logic              out_err_pad,
    output logic [CNT_W-1:0]  out_words_pad,
    output logic [CNT_W-1:0]  err_cnt_pad,
    input  logic              clr_cnt_pad
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic               acc, acc_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               mode, mode_nx;
    logic               res_par, res_par_nx;
    logic               res_err, res_err_nx;
    logic [CNT_W-1:0]   res_words, res_words_nx;
    logic [CNT_W-1:0]   err_cnt;

    logic               accept;
    logic               retire;
    logic               start;
    logic               word_par;
    logic               frame_mode;
    logic               frame_acc;
    logic               frame_par;
    logic [CNT_W-1:0]   frame_cnt;

    // The buffer frees up in the same cycle it retires, so a new frame can
    // start without a bubble while the previous result is being consumed.
    assign in_ready_pad = (state != HOLD) || out_ready_pad;
    assign accept       = in_valid_pad && in_ready_pad;
    assign retire       = (state == HOLD) && out_ready_pad;

    // A word accepted outside ACC always opens a new frame (from IDLE, or
    // from HOLD while the old result retires).
    assign start      = accept && (state != ACC);
    assign word_par   = ^in_data_pad;
    assign frame_mode = start ? odd_mode_pad : mode;
    assign frame_acc  = start ? word_par : (acc ^ word_par);
    assign frame_cnt  = start ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
    assign frame_par  = frame_mode ? frame_acc : ~frame_acc;

    assign out_valid_pad = (state == HOLD);
    assign out_par_pad   = res_par;
    assign out_err_pad   = res_err;
    assign out_words_pad = res_words;
    assign err_cnt_pad   = err_cnt;

    // State, frame accumulator and result buffer registers
    always_ff @(posedge clk_pad) begin
        if (!rst_n_pad) begin
            state     <= IDLE;
            acc       <= 1'b0;
            cnt       <= '0;
            mode      <= 1'b0;
            res_par   <= 1'b0;
            res_err   <= 1'b0;
            res_words <= '0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
            mode      <= mode_nx;
            res_par   <= res_par_nx;
            res_err   <= res_err_nx;
            res_words <= res_words_nx;
        end
    end

    // Next-state and next-datapath logic for frame accumulation and hand-off
    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        cnt_nx       = cnt;
        mode_nx      = mode;
        res_par_nx   = res_par;
        res_err_nx   = res_err;
        res_words_nx = res_words;

        case (state)
            IDLE:    state_nx = IDLE;
            ACC:     state_nx = ACC;
            HOLD:    if (retire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (accept) begin
            mode_nx = frame_mode;
            acc_nx  = frame_acc;
            cnt_nx  = frame_cnt;
            if (in_last_pad) begin
                state_nx     = HOLD;
                res_par_nx   = frame_par;
                res_err_nx   = frame_par ^ in_par_pad;
                res_words_nx = frame_cnt;
            end else begin
                state_nx = ACC;
            end
        end
    end

    // Saturating count of retired frames that carried a parity error; clear has priority
    always_ff @(posedge clk_pad) begin
        if (!rst_n_pad) begin
            err_cnt <= '0;
        end else if (clr_cnt_pad) begin
            err_cnt <= '0;
        end else if (retire && res_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - self-checking bench with behavioural frame model
module tb_parity_frame_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        odd_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_par = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_cnt = 1'b0;

    logic        in_ready_a, out_valid_a, out_par_a, out_err_a;
    logic [7:0]  out_words_a, err_cnt_a;
    logic        in_ready_b, out_valid_b, out_par_b, out_err_b;
    logic [1:0]  out_words_b, err_cnt_b;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(16), .CNT_W(8)) dut_a (
        .clk_pad(clk), .rst_n_pad(rst_n), .odd_mode_pad(odd_mode),
        .in_valid_pad(in_valid), .in_ready_pad(in_ready_a), .in_data_pad(in_data),
        .in_last_pad(in_last), .in_par_pad(in_par),
        .out_valid_pad(out_valid_a), .out_ready_pad(out_ready), .out_par_pad(out_par_a),
        .out_err_pad(out_err_a), .out_words_pad(out_words_a), .err_cnt_pad(err_cnt_a),
        .clr_cnt_pad(clr_cnt)
    );

    parity_frame_checker #(.DATA_W(16), .CNT_W(2)) dut_b (
        .clk_pad(clk), .rst_n_pad(rst_n), .odd_mode_pad(odd_mode),
        .in_valid_pad(in_valid), .in_ready_pad(in_ready_b), .in_data_pad(in_data),
        .in_last_pad(in_last), .in_par_pad(in_par),
        .out_valid_pad(out_valid_b), .out_ready_pad(out_ready), .out_par_pad(out_par_b),
        .out_err_pad(out_err_b), .out_words_pad(out_words_b), .err_cnt_pad(err_cnt_b),
        .clr_cnt_pad(clr_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts ones across the frame and saturates counts arithmetically
    bit exp_valid = 0, exp_par = 0, exp_err = 0;
    int exp_words = 0, exp_errs = 0;
    bit in_frame = 0, frame_mode = 0;
    int frame_ones = 0, frame_n = 0;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk) begin
        bit ready, retire;
        if (!rst_n) begin
            exp_valid = 0; exp_par = 0; exp_err = 0; exp_words = 0; exp_errs = 0;
            in_frame = 0; frame_ones = 0; frame_n = 0; frame_mode = 0;
        end else begin
            ready  = !exp_valid || out_ready;
            retire = exp_valid && out_ready;
            if (clr_cnt) exp_errs = 0;
            else if (retire && exp_err) exp_errs = exp_errs + 1;
            if (retire) exp_valid = 0;
            if (in_valid && ready) begin
                if (!in_frame) begin
                    in_frame = 1; frame_mode = odd_mode; frame_ones = 0; frame_n = 0;
                end
                frame_ones += $countones(in_data);
                frame_n++;
                if (in_last) begin
                    exp_par   = frame_mode ? frame_ones[0] : !frame_ones[0];
                    exp_err   = exp_par ^ in_par;
                    exp_words = frame_n;
                    exp_valid = 1;
                    in_frame  = 0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready_a", in_ready_a, !exp_valid || out_ready);
            chk("in_ready_b", in_ready_b, !exp_valid || out_ready);
            chk("out_valid_a", out_valid_a, exp_valid);
            chk("out_valid_b", out_valid_b, exp_valid);
            chk("err_cnt_a", err_cnt_a, sat(exp_errs, 255));
            chk("err_cnt_b", err_cnt_b, sat(exp_errs, 3));
            if (exp_valid) begin
                chk("out_par_a", out_par_a, exp_par);
                chk("out_par_b", out_par_b, exp_par);
                chk("out_err_a", out_err_a, exp_err);
                chk("out_err_b", out_err_b, exp_err);
                chk("out_words_a", out_words_a, sat(exp_words, 255));
                chk("out_words_b", out_words_b, sat(exp_words, 3));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic word(input logic [15:0] d, input logic last, input logic mode, input logic par);
        in_valid = 1; in_data = d; in_last = last; odd_mode = mode; in_par = par;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_valid", out_valid_a, 0);
        chk("rst_par", out_par_a, 0);
        chk("rst_err", out_err_a, 0);
        chk("rst_words", out_words_a, 0);
        chk("rst_errcnt", err_cnt_a, 0);
        chk("rst_ready", in_ready_a, 1);
        rst_n = 1;
        cmp_en = 1;

        // Single word 0xFFFF, even mode
        word(16'hFFFF, 1, 0, 1);
        step();
        chk("t1_valid", out_valid_a, 1);
        chk("t1_par", out_par_a, 1);
        chk("t1_err", out_err_a, 0);
        chk("t1_words", out_words_a, 1);
        in_valid = 0; out_ready = 1;
        step();
        chk("t1_errcnt", err_cnt_a, 0);
        chk("t1_retired", out_valid_a, 0);

        // Three-word odd frame, mode toggled on word 2 is ignored
        out_ready = 0;
        word(16'h0001, 0, 1, 0); step();
        word(16'h0000, 0, 0, 0); step();
        word(16'h0003, 1, 0, 0); step();
        chk("t2_par", out_par_a, 1);
        chk("t2_err", out_err_a, 1);
        chk("t2_words", out_words_a, 3);

        // Backpressure with a waiting word
        word(16'h0007, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ready", in_ready_a, 0);
            chk("bp_valid", out_valid_a, 1);
            chk("bp_words", out_words_a, 3);
        end
        out_ready = 1;
        step();
        chk("b2b_errcnt", err_cnt_a, 1);
        chk("b2b_valid", out_valid_a, 1);
        chk("b2b_par", out_par_a, 0);
        chk("b2b_words", out_words_a, 1);
        in_valid = 0;
        step();

        // Word count and error count saturation on the narrow instance
        word(16'h0000, 0, 0, 0);
        repeat (4) step();
        in_last = 1;
        step();
        chk("sat_words_a", out_words_a, 5);
        chk("sat_words_b", out_words_b, 3);
        repeat (5) step();
        in_valid = 0;
        step();
        chk("sat_errcnt_a", err_cnt_a, 7);
        chk("sat_errcnt_b", err_cnt_b, 3);
        word(16'h0000, 1, 0, 0);
        step();
        in_valid = 0; clr_cnt = 1;
        step();
        clr_cnt = 0;
        chk("clr_a", err_cnt_a, 0);
        chk("clr_b", err_cnt_b, 0);

        // Reset during word 2 drops the frame
        word(16'h0F0F, 0, 0, 0); step();
        word(16'h00FF, 0, 0, 0); rst_n = 0; step();
        rst_n = 1; in_valid = 0;
        chk("mrst_valid", out_valid_a, 0);
        chk("mrst_words", out_words_a, 0);
        chk("mrst_par", out_par_a, 0);
        word(16'h0001, 1, 1, 1); step();
        chk("mrst_next_par", out_par_a, 1);
        chk("mrst_next_err", out_err_a, 0);
        chk("mrst_next_words", out_words_a, 1);
        in_valid = 0;
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            odd_mode  = 1'($urandom);
            in_par    = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            clr_cnt   = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Streaming, parametrised successor to the fixed 16-input combinational parity tree.
- Accumulates parity over multi-word frames of DATA_W-bit words through a valid/ready handshake.
- Selects even or odd mode per frame and checks the result against a received parity bit.
- Holds a one-entry result buffer with backpressure, a per-frame word count, and a saturating error counter. Sits between a parallel data source and the link-integrity monitor.

Parameters:
DATA_W, 16, width of each data word; any value >= 1
CNT_W, 8, width of the word counter and the error counter

Ports:
clk_pad  in  1  single clock; all logic on its rising edge
rst_n_pad  in  1  reset, synchronous, active-low
odd_mode_pad  in  1  parity mode; sampled with the first word of each frame
in_valid_pad  in  1  input word valid
in_ready_pad  out  1  block can accept a word
in_data_pad  in  DATA_W  data word
in_last_pad  in  1  marks the final word of a frame
in_par_pad  in  1  expected parity bit; meaningful only with in_last_pad
out_valid_pad  out  1  frame result valid
out_ready_pad  in  1  downstream accepts the result
out_par_pad  out  1  computed frame parity
out_err_pad  out  1  out_par_pad != sampled in_par_pad
out_words_pad  out  CNT_W  words in the frame, saturating
err_cnt_pad  out  CNT_W  saturating count of frames with errors
clr_cnt_pad  in  1  synchronous clear of err_cnt_pad

Behaviour:
- Reset (rst_n_pad=0 at an edge):
  - state=IDLE; accumulator=0; word count=0; mode register=0.
  - out_valid_pad=0, out_par_pad=0, out_err_pad=0, out_words_pad=0, err_cnt_pad=0.
  - in_ready_pad=1 after reset (it is 0 only in HOLD).
  - Reset mid-frame or in HOLD drops the partial frame or the pending result with no output.
- Accept: a word is accepted when in_valid_pad && in_ready_pad.
- Frame parity: P = XOR of all DATA_W bits of every word in the frame.
  - Mode 0 (even): out_par_pad = ~P, which matches the legacy single-word block, i.e. 1 when the ones-count is even.
  - Mode 1 (odd): out_par_pad = P.
- States:
  - IDLE: the first accepted word latches odd_mode_pad, loads acc=^word and count=1.
    - If in_last_pad=1 the frame is single-word: go to HOLD. Otherwise go to ACC.
  - ACC: each accepted word does acc ^= ^word and count += 1, saturating at 2^CNT_W-1.
    - A word with in_last_pad=1 goes to HOLD.
    - odd_mode_pad changes are ignored mid-frame.
  - HOLD: out_valid_pad=1 and outputs are stable.
    - On out_ready_pad=1 the result retires.
    - The same cycle, in_ready_pad=out_ready_pad, so the first word of the next frame may be accepted while the result retires (back-to-back, no bubble). That word is handled as in IDLE.
    - If no word arrives, go to IDLE.
- Latency: the result appears registered on the cycle after the last word is accepted.
  - Throughput: one word per cycle; single-word frames sustain one frame per cycle when out_ready_pad is held at 1.
- Error: out_err_pad = out_par_pad ^ in_par_pad, with in_par_pad sampled on the last word.
  - err_cnt_pad increments by 1 when the result retires with out_err_pad=1; it saturates and does not wrap.
  - If clr_cnt_pad=1 and an increment happen in the same cycle, clear wins and the count becomes 0.
- No input: in_valid_pad=0 throughout produces no state change and no result.

Test Plan:
- Reset, then one word DATA_W=16, 0xFFFF, last=1, mode 0, in_par=1 -> next cycle out_valid=1, out_par=1, out_err=0, out_words=1; err_cnt stays 0.
- Frame 0x0001, 0x0000, 0x0003 (last), mode 1, in_par=0 -> P=1, so out_par=1, out_err=1, out_words=3; err_cnt=1 after retire.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no words consumed. Then out_ready=1 -> result retires and the next frame's first word is accepted the same cycle.
- CNT_W=2, 5-word frame -> out_words=3 (saturated). Five error frames -> err_cnt=3. clr_cnt asserted together with an error retire -> err_cnt=0.
- Toggle odd_mode_pad during word 2 of a 3-word frame -> mode from word 1 is used.
- Assert rst_n_pad=0 during word 2 -> no result; all outputs 0; the next frame is computed correctly from scratch.
